// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared period counter, debounced duty buttons,
// saturating double-buffered duty registers, edge- or centre-aligned compare.
module pwm_multi_gen #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 8,
    parameter int PERIOD      = 50,
    parameter int STEP_FINE   = 1,
    parameter int STEP_COARSE = 5,
    parameter int DB_CYCLES   = 500000,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic                inc,
    input  logic                inc1,
    input  logic                dec,
    input  logic                dec1,
    input  logic [SEL_W-1:0]    sel,
    input  logic                center_mode,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CNT_W-1:0]    duty_sel,
    output logic                period_start
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W:0]   PER_X    = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W:0]   FINE_X   = (CNT_W + 1)'(STEP_FINE);
    localparam logic [CNT_W:0]   COARSE_X = (CNT_W + 1)'(STEP_COARSE);
    localparam logic [DBW-1:0]   DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [SEL_W:0]   CH_X     = (SEL_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        OP_INC,
        OP_DEC,
        OP_DEC1,
        OP_INC1
    } op_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ps_q, ps_d;
    logic             wrap;

    logic [3:0]     btn_raw;
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     db_q, db_d;
    logic [3:0]     press_q, press_d;
    logic [DBW-1:0] dbcnt_q [4];
    logic [DBW-1:0] dbcnt_d [4];

    logic             sel_ok;
    logic             cmd_vld_q, cmd_vld_d;
    op_e              cmd_op_q, cmd_op_d;
    logic [SEL_W-1:0] cmd_ch_q, cmd_ch_d;

    logic [CNT_W-1:0] shadow_q [CHANNELS];
    logic [CNT_W-1:0] shadow_d [CHANNELS];
    logic [CNT_W-1:0] act_q    [CHANNELS];
    logic [CNT_W-1:0] act_d    [CHANNELS];
    logic             mode_q, mode_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;

    logic [CNT_W:0] cur_x, step_x, sum_x, nxt_x;
    logic           up;

    assign wrap    = (cnt_q == LAST);
    assign btn_raw = {inc1, dec1, dec, inc};
    assign sel_ok  = ({1'b0, sel} < CH_X);

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        ps_d  = wrap;
    end

    // Buttons are active low; a debounced falling level is a press.
    always_comb begin
        db_d    = db_q;
        press_d = '0;
        for (int b = 0; b < 4; b++) begin
            dbcnt_d[b] = '0;
            if (sync2_q[b] != db_q[b]) begin
                if (dbcnt_q[b] == DB_LAST) begin
                    db_d[b] = sync2_q[b];
                end else begin
                    dbcnt_d[b] = dbcnt_q[b] + DBW'(1);
                end
            end
            press_d[b] = db_q[b] & ~db_d[b];
        end
    end

    always_comb begin
        cmd_vld_d = 1'b0;
        cmd_op_d  = OP_INC;
        cmd_ch_d  = sel;
        if (sel_ok) begin
            if (press_q[0]) begin
                cmd_vld_d = 1'b1;
                cmd_op_d  = OP_INC;
            end else if (press_q[1]) begin
                cmd_vld_d = 1'b1;
                cmd_op_d  = OP_DEC;
            end else if (press_q[2]) begin
                cmd_vld_d = 1'b1;
                cmd_op_d  = OP_DEC1;
            end else if (press_q[3]) begin
                cmd_vld_d = 1'b1;
                cmd_op_d  = OP_INC1;
            end
        end
    end

    // One extra bit of headroom lets the sum be clamped to PERIOD.
    always_comb begin
        shadow_d = shadow_q;
        cur_x    = {1'b0, shadow_q[cmd_ch_q]};
        step_x   = FINE_X;
        up       = 1'b1;
        unique case (cmd_op_q)
            OP_INC:  begin step_x = FINE_X;   up = 1'b1; end
            OP_DEC:  begin step_x = FINE_X;   up = 1'b0; end
            OP_DEC1: begin step_x = COARSE_X; up = 1'b0; end
            OP_INC1: begin step_x = COARSE_X; up = 1'b1; end
            default: begin step_x = FINE_X;   up = 1'b1; end
        endcase
        sum_x = cur_x + step_x;
        if (up) begin
            nxt_x = (sum_x > PER_X) ? PER_X : sum_x;
        end else begin
            nxt_x = (cur_x < step_x) ? '0 : cur_x - step_x;
        end
        if (cmd_vld_q) begin
            shadow_d[cmd_ch_q] = nxt_x[CNT_W-1:0];
        end
    end

    always_comb begin
        act_d  = act_q;
        mode_d = mode_q;
        if (wrap) begin
            act_d  = shadow_q;
            mode_d = center_mode;
        end
    end

    function automatic logic cmp_hit(
        input logic [CNT_W-1:0] c,
        input logic [CNT_W-1:0] d,
        input logic             ctr
    );
        logic [CNT_W:0] c_x;
        logic [CNT_W:0] d_x;
        logic [CNT_W:0] lo_x;
        c_x  = {1'b0, c};
        d_x  = {1'b0, d};
        lo_x = (PER_X - d_x) >> 1;
        if (ctr) begin
            return (c_x >= lo_x) && (c_x < lo_x + d_x);
        end
        return c_x < d_x;
    endfunction

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = cmp_hit(cnt_q, act_q[i], mode_q);
        end
    end

    always_comb begin
        duty_sel = '0;
        if (sel_ok) begin
            duty_sel = shadow_q[sel];
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            ps_q      <= 1'b0;
            sync1_q   <= '1;
            sync2_q   <= '1;
            db_q      <= '1;
            press_q   <= '0;
            cmd_vld_q <= 1'b0;
            cmd_op_q  <= OP_INC;
            cmd_ch_q  <= '0;
            mode_q    <= 1'b0;
            pwm_q     <= '0;
            for (int b = 0; b < 4; b++) begin
                dbcnt_q[b] <= '0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                act_q[i]    <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            ps_q      <= ps_d;
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            press_q   <= press_d;
            cmd_vld_q <= cmd_vld_d;
            cmd_op_q  <= cmd_op_d;
            cmd_ch_q  <= cmd_ch_d;
            mode_q    <= mode_d;
            pwm_q     <= pwm_d;
            for (int b = 0; b < 4; b++) begin
                dbcnt_q[b] <= dbcnt_d[b];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                act_q[i]    <= act_d[i];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;

endmodule
